// File: rtl/fifo_arb_pkg.sv
// Purpose: shared encodings and helpers for the FIFO write-port arbiter.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package fifo_arb_pkg;

  // FSM state encoding
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  // grant_id / rr_ptr width, enough for up to 8 requesters
  localparam int GID_W = 3;

  // Round-robin successor of grantee g among nreq requesters
  function automatic logic [GID_W-1:0] rr_next(input logic [GID_W-1:0] g, input int nreq);
    return (int'(g) == nreq - 1) ? '0 : g + GID_W'(1);
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Purpose: round-robin picker, first set request scanning ptr, ptr+1, ... mod NREQ.
// Latency: purely combinational.
// Backpressure: none; a pure function of its inputs.
// Ports: req_i (request vector), ptr_i (scan start) -> onehot_o, idx_o (winner), any_o (any request).
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [GID_W-1:0] ptr_i,
  output logic [NREQ-1:0]  onehot_o,
  output logic [GID_W-1:0] idx_o,
  output logic             any_o
);

  // Walk the scan offsets from farthest to nearest so the nearest hit
  // is the last one written and therefore wins.
  always_comb begin
    onehot_o = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      for (int j = 0; j < NREQ; j++) begin
        if (req_i[j] && (j == ((int'(ptr_i) + k) % NREQ))) begin
          onehot_o    = '0;
          onehot_o[j] = 1'b1;
          idx_o       = GID_W'(j);
          any_o       = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Purpose: shares one FIFO write port among NREQ byte producers; round-robin, bounded bursts, null-byte drop.
// Latency: grant one cycle after request; beats pass to fifo_wr_en/fifo_wdata combinationally.
// Backpressure: fifo_full stalls non-null beats (ready low, grant and beat count hold); null beats still drain.
// Ports: clk_w/reset_n; req_valid/req_data/req_ready per requester; fifo_full in, fifo_wr_en/fifo_wdata out;
//        grant_id/busy show the current grant; drop_cnt counts suppressed null beats (saturating).
module fifo_wr_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int MAX_BURST = 4,
  parameter int DROP_NULL = 1
) (
  input  logic               clk_w,
  input  logic               reset_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_wdata,
  output logic [2:0]         grant_id,
  output logic               busy,
  output logic [15:0]        drop_cnt
);

  logic             state_q,  state_d;
  logic [GID_W-1:0] gnt_q,    gnt_d;
  logic [NREQ-1:0]  gnt_oh_q, gnt_oh_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0]       beat_q,   beat_d;
  logic [15:0]      drop_q,   drop_d;

  logic [NREQ-1:0]  pick_oh;
  logic [GID_W-1:0] pick_idx;
  logic             pick_any;

  logic             in_burst;
  logic             g_valid;
  logic [DW-1:0]    g_data;
  logic             is_null;
  logic             g_rdy;
  logic             accept;
  logic             last_beat;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i    (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  // The grant is also kept one-hot so the grantee's valid/data/ready
  // need no index decode.
  always_comb begin
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_oh_q[i]) g_data = req_data[i*DW +: DW];
    end
  end

  assign in_burst  = (state_q == ST_BURST);
  assign g_valid   = |(req_valid & gnt_oh_q);
  assign is_null   = (DROP_NULL != 0) && (g_data == '0);
  // Null beats never reach the FIFO, so they may drain while it is full
  assign g_rdy     = is_null | ~fifo_full;
  assign accept    = in_burst & g_valid & g_rdy;
  assign last_beat = (beat_q == 4'(MAX_BURST - 1));

  // State register
  always_ff @(posedge clk_w or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      gnt_oh_q <= '0;
      rr_ptr_q <= '0;
      beat_q   <= '0;
      drop_q   <= '0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_oh_q <= gnt_oh_d;
      rr_ptr_q <= rr_ptr_d;
      beat_q   <= beat_d;
      drop_q   <= drop_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_oh_d = gnt_oh_q;
    rr_ptr_d = rr_ptr_q;
    beat_d   = beat_q;
    drop_d   = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d  = ST_BURST;
          gnt_d    = pick_idx;
          gnt_oh_d = pick_oh;
          beat_d   = '0;
        end
      end
      ST_BURST: begin
        if (!g_valid) begin
          // Grantee dropped valid: its transfer is over
          state_d  = ST_IDLE;
          rr_ptr_d = rr_next(gnt_q, NREQ);
        end else if (accept) begin
          if (is_null && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
          if (last_beat) begin
            state_d  = ST_IDLE;
            rr_ptr_d = rr_next(gnt_q, NREQ);
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    req_ready  = (in_burst && g_rdy) ? gnt_oh_q : '0;
    fifo_wr_en = in_burst & g_valid & ~fifo_full & ~is_null;
    fifo_wdata = in_burst ? g_data : '0;
    busy       = in_burst;
    grant_id   = gnt_q;
    drop_cnt   = drop_q;
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Purpose: directed self-checking bench for fifo_wr_arb (NREQ=4, DW=8, MAX_BURST=4, DROP_NULL=1).
// Latency: inputs change 1 ns after the rising edge; outputs are sampled on the falling edge.
// Backpressure: each requester is a byte queue that pops only on valid & ready.
module tb_fifo_wr_arb;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic            clk_w = 1'b0;
  logic            reset_n;
  logic [NREQ-1:0] req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_wdata;
  logic [2:0]      grant_id;
  logic            busy;
  logic [15:0]     drop_cnt;

  always #5 clk_w = ~clk_w;

  fifo_wr_arb #(.NREQ(4), .DW(8), .MAX_BURST(4), .DROP_NULL(1)) u_dut (
    .clk_w      (clk_w),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr_en (fifo_wr_en),
    .fifo_wdata (fifo_wdata),
    .grant_id   (grant_id),
    .busy       (busy),
    .drop_cnt   (drop_cnt)
  );

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] src [NREQ][$];
  logic [7:0] cap[$];
  logic [7:0] exp_w[$];
  int         gnt_log[$];
  int         exp_g[$];
  logic [NREQ-1:0] acc = '0;
  logic            busy_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Falling-edge monitor: FIFO writes, grant starts, accepted beats, safety properties
  always @(negedge clk_w) begin
    acc = req_valid & req_ready;
    if (fifo_wr_en) cap.push_back(fifo_wdata);
    if (busy && !busy_prev) gnt_log.push_back(int'(grant_id));
    busy_prev = busy;
    chk("no_ovf", fifo_wr_en & fifo_full, 1'b0);
    chk("rdy_1hot", $countones(req_ready) <= 1, 1'b1);
  end

  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i]         = (src[i].size() > 0);
      req_data[i*DW +: DW] = (src[i].size() > 0) ? src[i][0] : 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk_w);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i] && src[i].size() > 0) void'(src[i].pop_front());
    end
    drive();
  endtask

  function automatic bit srcs_empty();
    bit e = 1'b1;
    for (int i = 0; i < NREQ; i++) if (src[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 200; c++) begin
      tick();
      #1;
      if (srcs_empty() && !busy) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain_done", done, 1'b1);
    tick();
  endtask

  task automatic cmp(input string tag);
    chk($sformatf("%s_nwr", tag), cap.size(), exp_w.size());
    for (int i = 0; i < exp_w.size() && i < cap.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), cap[i], exp_w[i]);
    chk($sformatf("%s_ngnt", tag), gnt_log.size(), exp_g.size());
    for (int i = 0; i < exp_g.size() && i < gnt_log.size(); i++)
      chk($sformatf("%s_gnt%0d", tag, i), gnt_log[i], exp_g[i]);
    cap.delete();
    exp_w.delete();
    gnt_log.delete();
    exp_g.delete();
  endtask

  initial begin
    reset_n   = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;

    // Reset with every requester valid, then full-rate round robin
    for (int b = 0; b < 8; b++) src[0].push_back(8'h11);
    for (int b = 0; b < 4; b++) src[1].push_back(8'h22);
    for (int b = 0; b < 4; b++) src[2].push_back(8'h33);
    for (int b = 0; b < 4; b++) src[3].push_back(8'h44);
    drive();
    tick();
    tick();
    #1;
    chk("rst_ready", req_ready, 4'b0000);
    chk("rst_wr_en", fifo_wr_en, 1'b0);
    chk("rst_wdata", fifo_wdata, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant_id, 3'd0);
    chk("rst_drop", drop_cnt, 16'd0);
    reset_n = 1'b1;
    tick();
    #1;
    chk("first_busy", busy, 1'b1);
    chk("first_grant", grant_id, 3'd0);
    chk("first_ready", req_ready, 4'b0001);
    chk("first_wr_en", fifo_wr_en, 1'b1);
    chk("first_wdata", fifo_wdata, 8'h11);
    drain();
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < 4; b++) exp_w.push_back((r == 4) ? 8'h11 : 8'(8'h11 * (r + 1)));
    exp_g = '{0, 1, 2, 3, 0};
    cmp("rr");

    // Backpressure: FIFO full for 5 cycles after two beats of req1
    src[1] = '{8'h51, 8'h52, 8'h53, 8'h54};
    tick();
    tick();
    tick();
    tick();
    fifo_full = 1'b1;
    #1;
    chk("bp_wr_en", fifo_wr_en, 1'b0);
    chk("bp_ready", req_ready, 4'b0000);
    chk("bp_busy", busy, 1'b1);
    chk("bp_grant", grant_id, 3'd1);
    repeat (5) tick();
    chk("bp_hold", cap.size(), 2);
    fifo_full = 1'b0;
    #1;
    chk("bp_resume_en", fifo_wr_en, 1'b1);
    chk("bp_resume_dat", fifo_wdata, 8'h53);
    drain();
    exp_w = '{8'h51, 8'h52, 8'h53, 8'h54};
    exp_g = '{1};
    cmp("bp");

    // Null drop: 05,00,00,07 from req1; the nulls drain while full
    src[1] = '{8'h05, 8'h00, 8'h00, 8'h07};
    tick();
    tick();
    #1;
    chk("null_first_rdy", req_ready, 4'b0010);
    tick();
    fifo_full = 1'b1;
    #1;
    chk("null_rdy_full", req_ready, 4'b0010);
    chk("null_no_wr", fifo_wr_en, 1'b0);
    tick();
    #1;
    chk("null_drop1", drop_cnt, 16'd1);
    tick();
    #1;
    chk("null_data_stall", req_ready, 4'b0000);
    chk("null_drop2", drop_cnt, 16'd2);
    fifo_full = 1'b0;
    drain();
    chk("null_drop_end", drop_cnt, 16'd2);
    exp_w = '{8'h05, 8'h07};
    exp_g = '{1};
    cmp("null");

    // Short burst: req2 sends 2 beats, then req3 is next even though req0 waits
    src[2] = '{8'h61, 8'h62};
    src[0] = '{8'h71};
    src[3] = '{8'h81};
    tick();
    tick();
    #1;
    chk("short_grant", grant_id, 3'd2);
    tick();
    tick();
    #1;
    chk("short_tail_busy", busy, 1'b1);
    chk("short_tail_wr", fifo_wr_en, 1'b0);
    tick();
    #1;
    chk("short_idle", busy, 1'b0);
    tick();
    #1;
    chk("short_next_busy", busy, 1'b1);
    chk("short_next_grant", grant_id, 3'd3);
    drain();
    exp_w = '{8'h61, 8'h62, 8'h81, 8'h71};
    exp_g = '{2, 3, 0};
    cmp("short");

    // Reset mid-burst after two beats of req1
    src[1] = '{8'h91, 8'h92, 8'h93, 8'h94};
    tick();
    tick();
    tick();
    tick();
    #1;
    chk("pre_rst_wr", fifo_wr_en, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_wr", fifo_wr_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_ready", req_ready, 4'b0000);
    chk("mid_rst_wdata", fifo_wdata, 8'h00);
    chk("mid_rst_drop", drop_cnt, 16'd0);
    src[0] = '{8'hA1};
    tick();
    reset_n = 1'b1;
    tick();
    #1;
    chk("post_rst_busy", busy, 1'b1);
    chk("post_rst_grant", grant_id, 3'd0);
    drain();
    exp_w = '{8'h91, 8'h92, 8'hA1, 8'h93, 8'h94};
    exp_g = '{1, 0, 1};
    cmp("rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
